// File: rtl/traffic_pkg.sv
// Shared light codes, controller states and the lights-vector builder.
// Optional pedestrian phase is enabled with TRAFFIC_PED_PHASE_EN.
package traffic_pkg;

  localparam logic [1:0] LT_R = 2'b00;
  localparam logic [1:0] LT_Y = 2'b01;
  localparam logic [1:0] LT_G = 2'b10;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_WALK   = 2'd3
  } state_e;

  // Built for up to 8 ways; callers truncate to their own width.
  function automatic logic [15:0] build_lights(
    input state_e     st,
    input logic [2:0] idx,
    input logic [3:0] n
  );
    logic [15:0] v;
    logic [2:0]  nxt;
    v   = '0;
    nxt = (idx == 3'(n - 4'd1)) ? 3'd0 : idx + 3'd1;
    case (st)
      ST_INIT: begin
        for (int k = 0; k < 8; k++) v[k*2 +: 2] = LT_Y;
      end
      ST_GREEN: v[int'(idx)*2 +: 2] = LT_G;
      ST_YELLOW: begin
        v[int'(idx)*2 +: 2] = LT_Y;
        v[int'(nxt)*2 +: 2] = LT_Y;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_timer.sv
// Loadable, tick-gated phase down-counter with zero flag.
// A zero length is clamped so that every phase lasts at least one tick.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (len == '0) ? '0 : len - CNT_W'(1);
    end else if (tick && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin traffic phase controller: INIT, GREEN, YELLOW, optional WALK.
// Pedestrian phase is compiled in with TRAFFIC_PED_PHASE_EN.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter  int NUM_WAYS = 4,
  parameter  int CNT_W    = 8,
  localparam int IW       = (NUM_WAYS > 2) ? $clog2(NUM_WAYS) : 1,
  localparam int LW       = 2 * NUM_WAYS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [CNT_W-1:0] green_len,
  input  logic [CNT_W-1:0] yellow_len,
  input  logic             ped_req,
  output logic [LW-1:0]    lights,
  output logic [IW-1:0]    phase_idx,
  output logic             ped_walk,
  output logic             phase_start
);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d, nxt_idx;
  logic [LW-1:0]    lights_q, lights_d;
  logic             start_q, start_d;
  logic             tmr_load, tmr_zero, adv;
  logic [CNT_W-1:0] tmr_len;

`ifdef TRAFFIC_PED_PHASE_EN
  logic ped_pend_q, ped_pend_d;
  logic walk_q, walk_d;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
`endif

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .load  (tmr_load),
    .len   (tmr_len),
    .zero  (tmr_zero)
  );

  assign adv     = tick & tmr_zero;
  assign nxt_idx = (idx_q == IW'(NUM_WAYS - 1)) ? '0 : idx_q + IW'(1);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_len  = green_len;
    case (state_q)
      ST_INIT: if (adv) begin
        state_d  = ST_GREEN;
        idx_d    = '0;
        tmr_load = 1'b1;
      end
      ST_GREEN: if (adv) begin
        state_d  = ST_YELLOW;
        tmr_load = 1'b1;
        tmr_len  = yellow_len;
      end
      ST_YELLOW: if (adv) begin
        tmr_load = 1'b1;
`ifdef TRAFFIC_PED_PHASE_EN
        if (ped_pend_q) begin
          state_d = ST_WALK;
        end else begin
          state_d = ST_GREEN;
          idx_d   = nxt_idx;
        end
`else
        state_d = ST_GREEN;
        idx_d   = nxt_idx;
`endif
      end
`ifdef TRAFFIC_PED_PHASE_EN
      ST_WALK: if (adv) begin
        state_d  = ST_GREEN;
        idx_d    = nxt_idx;
        tmr_load = 1'b1;
      end
`endif
      // Unreachable encodings recover through INIT with a one-tick timer.
      default: begin
        state_d  = ST_INIT;
        idx_d    = '0;
        tmr_load = 1'b1;
        tmr_len  = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so they line up with entry.
  always_comb begin
    start_d  = (state_d != state_q);
    lights_d = LW'(build_lights(state_d, 3'(idx_d), 4'(NUM_WAYS)));
  end

`ifdef TRAFFIC_PED_PHASE_EN
  always_comb begin
    walk_d     = (state_d == ST_WALK);
    ped_pend_d = ped_req |
                 (ped_pend_q & ~(walk_d && state_q != ST_WALK));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
    end
  end

  assign ped_walk = walk_q;
`else
  assign ped_walk = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      idx_q    <= '0;
      lights_q <= {NUM_WAYS{LT_Y}};
      start_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lights_q <= lights_d;
      start_q  <= start_d;
    end
  end

  assign lights      = lights_q;
  assign phase_idx   = idx_q;
  assign phase_start = start_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl against a phase-schedule model.
// Build with TRAFFIC_PED_PHASE_EN defined to exercise the WALK phase.
module tb_traffic_phase_ctrl;

  localparam int NW = 4;
  localparam int CW = 8;
`ifdef TRAFFIC_PED_PHASE_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  // Model phase kinds
  localparam int K_INIT  = 0;
  localparam int K_GREEN = 1;
  localparam int K_YEL   = 2;
  localparam int K_WALK  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick;
  logic [CW-1:0] green_len;
  logic [CW-1:0] yellow_len;
  logic          ped_req;
  logic [2*NW-1:0] lights;
  logic [1:0]    phase_idx;
  logic          ped_walk;
  logic          phase_start;

  traffic_phase_ctrl #(.NUM_WAYS(NW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .green_len   (green_len),
    .yellow_len  (yellow_len),
    .ped_req     (ped_req),
    .lights      (lights),
    .phase_idx   (phase_idx),
    .ped_walk    (ped_walk),
    .phase_start (phase_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Model: current phase kind, owning way, ticks still needed, start flag
  int m_kind, m_way, m_left;
  bit m_start, m_pend;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    fails++;
    $error("FAIL %s timeout waiting for phase", tag);
  endtask

  function automatic logic [2*NW-1:0] exp_lights(input int kind,
                                                  input int way);
    logic [2*NW-1:0] v;
    v = '0;
    for (int k = 0; k < NW; k++) begin
      if (kind == K_INIT) v[k*2 +: 2] = 2'b01;
      else if (kind == K_GREEN && k == way) v[k*2 +: 2] = 2'b10;
      else if (kind == K_YEL && (k == way || k == (way + 1) % NW))
        v[k*2 +: 2] = 2'b01;
    end
    return v;
  endfunction

  function automatic logic unsafe(input logic [2*NW-1:0] l);
    int g, y;
    logic bad;
    g = 0; y = 0; bad = 1'b0;
    for (int k = 0; k < NW; k++) begin
      if (l[k*2 +: 2] == 2'b10) g++;
      if (l[k*2 +: 2] == 2'b01) y++;
      if (l[k*2 +: 2] == 2'b11) bad = 1'b1;
    end
    return bad || g > 1 || (g == 1 && y > 0);
  endfunction

  function automatic int clamp(input logic [CW-1:0] len);
    return (len == 0) ? 1 : int'(len);
  endfunction

  task automatic model_edge();
    bit adv;
    bit np;
    adv = 1'b0;
    if (!rst_n) begin
      m_kind = K_INIT; m_way = 0; m_left = 1;
      m_start = 1'b1; m_pend = 1'b0;
      return;
    end
    np = m_pend | (PED & ped_req);
    if (tick) begin
      m_left--;
      adv = (m_left == 0);
    end
    m_start = adv;
    if (adv) begin
      if (m_kind == K_INIT) begin
        m_kind = K_GREEN; m_way = 0; m_left = clamp(green_len);
      end else if (m_kind == K_GREEN) begin
        m_kind = K_YEL; m_left = clamp(yellow_len);
      end else if (m_kind == K_YEL && PED && m_pend) begin
        m_kind = K_WALK; m_left = clamp(green_len);
        np = ped_req;
      end else begin
        m_kind = K_GREEN; m_way = (m_way + 1) % NW;
        m_left = clamp(green_len);
      end
    end
    m_pend = np;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("lights", 32'(lights), 32'(exp_lights(m_kind, m_way)));
    chk("phase_idx", 32'(phase_idx), 32'(m_way));
    chk("ped_walk", 32'(ped_walk), 32'(m_kind == K_WALK));
    chk("phase_start", 32'(phase_start), 32'(m_start));
    chk("safety", 32'(unsafe(lights)), 32'd0);
  endtask

  task automatic wait_phase(input string tag, input int kind,
                            input int way);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(m_start && m_kind == kind && m_way == way) && n < 200);
    if (n >= 200) timeout(tag);
  endtask

  // Called in a phase's first cycle; returns its length in cycles.
  task automatic measure(output int len);
    len = 1;
    cycle();
    while (!phase_start && len < 100) begin
      len++;
      cycle();
    end
  endtask

  logic [2*NW-1:0] tbl_l [10];
  int              tbl_d [10];
  int              cnt, starts, plen;
  bit              was_g;

  initial begin
    tbl_l = '{8'h55, 8'h02, 8'h05, 8'h08, 8'h14,
              8'h20, 8'h50, 8'h80, 8'h41, 8'h02};
    tbl_d = '{1, 3, 2, 3, 2, 3, 2, 3, 2, 3};
    rst_n = 1'b0; tick = 1'b1; green_len = 8'd3; yellow_len = 8'd2;
    ped_req = !PED;
    cycle();
    cycle();
    chk("reset_lights", 32'(lights), 32'h55);
    chk("reset_idx", 32'(phase_idx), 32'd0);
    chk("reset_start", 32'(phase_start), 32'd1);

    // Fixed sequence with wrap from way 3 back to way 0
    rst_n = 1'b1;
    for (int p = 0; p < 10; p++) begin
      for (int d = 0; d < tbl_d[p]; d++) begin
        chk("seq_lights", 32'(lights), 32'(tbl_l[p]));
        chk("seq_start", 32'(phase_start), 32'(d == 0));
        cycle();
      end
    end
    ped_req = 1'b0;

    // Tick every 4th cycle: each 2-tick GREEN spans 8 cycles
    green_len = 8'd2;
    cnt = 0; starts = 0; was_g = 1'b0;
    for (int n = 0; n < 96; n++) begin
      tick = (n % 4 == 0);
      cycle();
      if (phase_start) begin
        if (starts >= 1 && was_g) chk("green_8cyc", 32'(cnt), 32'd8);
        starts++;
        cnt = 0;
        was_g = 1'b0;
        for (int k = 0; k < NW; k++)
          if (lights[k*2 +: 2] == 2'b10) was_g = 1'b1;
      end
      cnt++;
    end

    // Zero lengths clamp to one tick
    tick = 1'b1; green_len = 8'd0; yellow_len = 8'd0;
    for (int n = 0; n < 4; n++) cycle();
    for (int n = 0; n < 8; n++) begin
      cycle();
      chk("len0_start", 32'(phase_start), 32'd1);
    end

    // Mid-GREEN length change only affects the following GREEN
    green_len = 8'd3;
    wait_phase("g3", K_GREEN, (m_way + 1) % NW);
    green_len = 8'd9;
    measure(plen);
    chk("green_keep3", 32'(plen), 32'd3);
    measure(plen);
    chk("yellow_1", 32'(plen), 32'd1);
    measure(plen);
    chk("green_new9", 32'(plen), 32'd9);

    // Reset mid GREEN(2)
    green_len = 8'd3; yellow_len = 8'd2;
    wait_phase("g2", K_GREEN, 2);
    cycle();
    rst_n = 1'b0;
    cycle();
    chk("rst_mid_lights", 32'(lights), 32'h55);
    chk("rst_mid_idx", 32'(phase_idx), 32'd0);
    chk("rst_mid_start", 32'(phase_start), 32'd1);
    rst_n = 1'b1;
    cycle();
    chk("rst_mid_green0", 32'(lights), 32'h02);

`ifdef TRAFFIC_PED_PHASE_EN
    wait_phase("g1", K_GREEN, 1);
    ped_req = 1'b1;
    cycle();
    ped_req = 1'b0;
    wait_phase("walk1", K_WALK, 1);
    chk("walk_lights", 32'(lights), 32'h00);
    chk("walk_flag", 32'(ped_walk), 32'd1);
    ped_req = 1'b1;
    measure(plen);
    ped_req = 1'b0;
    chk("walk_len", 32'(plen), 32'd3);
    chk("after_walk", 32'(lights), 32'h20);
    wait_phase("walk2", K_WALK, 2);
    chk("walk2_flag", 32'(ped_walk), 32'd1);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      tick       = ($urandom_range(0, 2) != 0);
      green_len  = 8'($urandom_range(0, 4));
      yellow_len = 8'($urandom_range(0, 3));
      ped_req    = ($urandom_range(0, 15) == 0);
      rst_n      = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
